apf_dict_loader: RTL

- Bridge-side register and load engine between the APF bridge and translation_overlay_top.
- Decodes bridge reads and writes into the overlay config registers (cfg_*).
- Streams dictionary entries from bridge writes into the dict_load_* port.
- Serialises 32-bit bloom-filter words into single-bit bloom_load_* writes.

---
 rtl/apf_dict_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/apf_dict_loader.sv
// Bridge register block for the translation overlay: config registers, dictionary
// entry streaming and a bloom-word serialiser that emits one bit per cycle.
module apf_dict_loader #(
    parameter logic [31:0] BASE_ADDR = 32'hF800_0000,
    parameter int          DICT_W    = 41,
    parameter int          LOAD_AW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        bridge_addr,
    input  logic               bridge_rd,
    output logic [31:0]        bridge_rd_data,
    input  logic               bridge_wr,
    input  logic [31:0]        bridge_wr_data,
    output logic               dict_load_en,
    output logic [LOAD_AW-1:0] dict_load_addr,
    output logic [DICT_W-1:0]  dict_load_data,
    output logic               bloom_load_en,
    output logic [LOAD_AW-1:0] bloom_load_addr,
    output logic               bloom_load_bit,
    output logic               cfg_enable,
    output logic               cfg_mode,
    output logic [14:0]        cfg_caption_color,
    output logic [7:0]         cfg_caption_y
);
    localparam int HI_W = DICT_W - 32;

    localparam logic [31:0] OFF_CTRL      = 32'h00;
    localparam logic [31:0] OFF_COLOR     = 32'h04;
    localparam logic [31:0] OFF_CAPY      = 32'h08;
    localparam logic [31:0] OFF_STATUS    = 32'h0C;
    localparam logic [31:0] OFF_DICT_LO   = 32'h10;
    localparam logic [31:0] OFF_DICT_HI   = 32'h14;
    localparam logic [31:0] OFF_DICT_PTR  = 32'h18;
    localparam logic [31:0] OFF_BLOOM_WD  = 32'h20;
    localparam logic [31:0] OFF_BLOOM_PTR = 32'h24;

    typedef enum logic {IDLE, SHIFT} bloom_state_e;

    bloom_state_e       state_q, state_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               enable_q, enable_d;
    logic               mode_q, mode_d;
    logic [14:0]        color_q, color_d;
    logic [7:0]         capy_q, capy_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        dict_cnt_q, dict_cnt_d;
    logic [31:0]        dict_lo_q, dict_lo_d;
    logic [LOAD_AW-1:0] dict_ptr_q, dict_ptr_d;
    logic               dict_en_q, dict_en_d;
    logic [LOAD_AW-1:0] dict_addr_q, dict_addr_d;
    logic [DICT_W-1:0]  dict_data_q, dict_data_d;
    logic [31:0]        word_q, word_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [LOAD_AW-1:0] bloom_ptr_q, bloom_ptr_d;

    logic [31:0] off;
    logic        shifting;
    logic [31:0] rd_mux;

    assign off      = bridge_addr - BASE_ADDR;
    assign shifting = (state_q == SHIFT);

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:      rd_mux = {30'd0, mode_q, enable_q};
            OFF_COLOR:     rd_mux = {17'd0, color_q};
            OFF_CAPY:      rd_mux = {24'd0, capy_q};
            OFF_STATUS:    rd_mux = {dict_cnt_q, 14'd0, overrun_q, shifting};
            OFF_DICT_LO:   rd_mux = dict_lo_q;
            OFF_DICT_PTR:  rd_mux[LOAD_AW-1:0] = dict_ptr_q;
            OFF_BLOOM_PTR: rd_mux[LOAD_AW-1:0] = bloom_ptr_q;
            default:       rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        enable_d    = enable_q;
        mode_d      = mode_q;
        color_d     = color_q;
        capy_d      = capy_q;
        overrun_d   = overrun_q;
        dict_cnt_d  = dict_cnt_q;
        dict_lo_d   = dict_lo_q;
        dict_ptr_d  = dict_ptr_q;
        dict_en_d   = 1'b0;
        dict_addr_d = dict_addr_q;
        dict_data_d = dict_data_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        bloom_ptr_d = bloom_ptr_q;

        // Read mux samples pre-write state, so a same-cycle write is invisible here.
        if (bridge_rd)
            rd_data_d = rd_mux;

        if (shifting) begin
            bloom_ptr_d = bloom_ptr_q + 1'b1;
            cnt_d       = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
                state_d = IDLE;
        end

        if (bridge_wr) begin
            case (off)
                OFF_CTRL: begin
                    enable_d = bridge_wr_data[0];
                    mode_d   = bridge_wr_data[1];
                end
                OFF_COLOR: color_d = bridge_wr_data[14:0];
                OFF_CAPY:  capy_d  = bridge_wr_data[7:0];
                OFF_STATUS: begin
                    if (bridge_wr_data[1])
                        overrun_d = 1'b0;
                end
                OFF_DICT_LO: dict_lo_d = bridge_wr_data;
                OFF_DICT_HI: begin
                    dict_en_d   = 1'b1;
                    dict_addr_d = dict_ptr_q;
                    dict_data_d = {bridge_wr_data[HI_W-1:0], dict_lo_q};
                    dict_ptr_d  = dict_ptr_q + 1'b1;
                    if (dict_cnt_q != 16'hFFFF)
                        dict_cnt_d = dict_cnt_q + 16'd1;
                end
                OFF_DICT_PTR: dict_ptr_d = bridge_wr_data[LOAD_AW-1:0];
                OFF_BLOOM_WD: begin
                    if (shifting) begin
                        overrun_d = 1'b1;
                    end else begin
                        word_d  = bridge_wr_data;
                        cnt_d   = 5'd0;
                        state_d = SHIFT;
                    end
                end
                OFF_BLOOM_PTR: begin
                    if (shifting)
                        overrun_d = 1'b1;
                    else
                        bloom_ptr_d = bridge_wr_data[LOAD_AW-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_data_q   <= '0;
            enable_q    <= 1'b0;
            mode_q      <= 1'b0;
            color_q     <= 15'h7FFF;
            capy_q      <= 8'd128;
            overrun_q   <= 1'b0;
            dict_cnt_q  <= '0;
            dict_lo_q   <= '0;
            dict_ptr_q  <= '0;
            dict_en_q   <= 1'b0;
            dict_addr_q <= '0;
            dict_data_q <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            bloom_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_data_q   <= rd_data_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            color_q     <= color_d;
            capy_q      <= capy_d;
            overrun_q   <= overrun_d;
            dict_cnt_q  <= dict_cnt_d;
            dict_lo_q   <= dict_lo_d;
            dict_ptr_q  <= dict_ptr_d;
            dict_en_q   <= dict_en_d;
            dict_addr_q <= dict_addr_d;
            dict_data_q <= dict_data_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            bloom_ptr_q <= bloom_ptr_d;
        end
    end

    assign bridge_rd_data    = rd_data_q;
    assign dict_load_en      = dict_en_q;
    assign dict_load_addr    = dict_addr_q;
    assign dict_load_data    = dict_data_q;
    // Bloom outputs derive from the SHIFT state so reset silences them on the next cycle.
    assign bloom_load_en     = shifting;
    assign bloom_load_addr   = shifting ? bloom_ptr_q : '0;
    assign bloom_load_bit    = shifting & word_q[cnt_q];
    assign cfg_enable        = enable_q;
    assign cfg_mode          = mode_q;
    assign cfg_caption_color = color_q;
    assign cfg_caption_y     = capy_q;
endmodule
